// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: immediate format codes and the base opcode words
// used when generating instructions.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'b000,
    IMM_S  = 3'b001,
    IMM_B  = 3'b010,
    IMM_U  = 3'b011,
    IMM_J  = 3'b100,
    IMM_I2 = 3'b101
  } imm_src_e;

  localparam logic [31:0] OPC_OP_IMM = 32'h0000_0013;
  localparam logic [31:0] OPC_STORE  = 32'h0000_2023;
  localparam logic [31:0] OPC_BRANCH = 32'h0000_0063;
  localparam logic [31:0] OPC_LUI    = 32'h0000_0037;
  localparam logic [31:0] OPC_JAL    = 32'h0000_006F;

endpackage

// File: rtl/imm_encoder_pipe_if.sv
// Request/result handshake bundle for the immediate encoder pipeline.
interface imm_encoder_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base_instr;
  logic [31:0] imm;
  logic [2:0]  ImmSrc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  modport master (
    output in_valid, base_instr, imm, ImmSrc, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, base_instr, imm, ImmSrc, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/imm_field_pack.sv
// Combinational scatter of an immediate into an instruction word, with a flag for
// immediates the chosen format cannot represent or for an illegal format code.
module imm_field_pack
  import riscv_pkg::*;
(
  input  logic [31:0] base_instr,
  input  logic [31:0] imm,
  input  logic [2:0]  ImmSrc,
  output logic [31:0] instr,
  output logic        err
);

  // A field fits when every bit above its sign bit matches the sign bit.
  logic fits_12, fits_13, fits_21;
  assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    instr = base_instr;
    err   = 1'b0;
    case (ImmSrc)
      IMM_I, IMM_I2: begin
        instr[31:20] = imm[11:0];
        err          = ~fits_12;
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = ~fits_12;
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        err          = ~fits_13 | imm[0];
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
        err          = |imm[11:0];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        err          = ~fits_21 | imm[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder_pipe.sv
// Two-stage immediate encoder: S1 captures the request, S2 holds the encoded word.
// Both stages advance together whenever the output slot is free or being drained.
module imm_encoder_pipe
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  imm_encoder_pipe_if.slave  bus_io
);

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [2:0]  s1_src_q, s1_src_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        s2_can_load, accept;
  logic [31:0] pack_instr;
  logic        pack_err;

  imm_field_pack u_pack (
    .base_instr (s1_base_q),
    .imm        (s1_imm_q),
    .ImmSrc     (s1_src_q),
    .instr      (pack_instr),
    .err        (pack_err)
  );

  assign s2_can_load     = !s2_valid_q || bus_io.out_ready;
  assign bus_io.in_ready = !s1_valid_q || s2_can_load;
  assign accept          = bus_io.in_valid && bus_io.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_base_d  = s1_base_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_base_d  = bus_io.base_instr;
      s1_imm_d   = bus_io.imm;
      s1_src_d   = bus_io.ImmSrc;
    end else if (s2_can_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = pack_instr;
        s2_err_d   = pack_err;
      end
    end

    if (s2_valid_q && bus_io.out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_base_q  <= s1_base_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus_io.out_valid = s2_valid_q;
  assign bus_io.out_instr = s2_instr_q;
  assign bus_io.out_err   = s2_err_q;
  assign bus_io.err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder_pipe.sv
// Bench for imm_encoder_pipe: directed vector table, handshake corner sequences and
// random traffic scored against an arithmetic model of the encoding rules.
module tb_imm_encoder_pipe;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_encoder_pipe_if bus ();

  imm_encoder_pipe dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  int unsigned model_cnt;
  logic        last_acc;
  logic        held_v;
  logic [31:0] held_instr;
  logic        held_err;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Encoding from the format definitions, range limits taken as signed integer bounds.
  function automatic logic [32:0] ref_model(input logic [31:0] base, input logic [31:0] imm,
                                            input logic [2:0] src);
    int          s;
    logic        e;
    logic [31:0] w;
    s = $signed(imm);
    case (src)
      3'd0, 3'd5: begin
        w = {imm[11:0], base[19:0]};
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e = (s < -4096) || (s > 4095) || ((imm % 2) != 0);
      end
      3'd3: begin
        w = {imm[31:12], base[11:0]};
        e = (imm % 4096) != 0;
      end
      3'd4: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((imm % 2) != 0);
      end
      default: begin
        w = base;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return 32'($signed($urandom_range(0, 9000)) - 4500);
      1: return 32'($signed($urandom_range(0, 32'h0040_0000)) - 32'sh0020_0000);
      2: return {$urandom()} & 32'hFFFF_F000;
      default: return $urandom();
    endcase
  endfunction

  // One clock of stimulus; scores any result consumed and checks stall stability.
  task automatic cycle(input logic v, input logic [31:0] b, input logic [31:0] i,
                       input logic [2:0] s, input logic ordy);
    logic [32:0] e;
    bus.in_valid   = v;
    bus.base_instr = b;
    bus.imm        = i;
    bus.ImmSrc     = s;
    bus.out_ready  = ordy;
    #1;
    last_acc = v && bus.in_ready;
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", bus.out_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", bus.out_instr, e[31:0]);
        check("out_err", {31'b0, bus.out_err}, {31'b0, e[32]});
        if (e[32] && model_cnt < 255) model_cnt++;
      end
    end
    held_v     = bus.out_valid && !ordy;
    held_instr = bus.out_instr;
    held_err   = bus.out_err;
    if (last_acc) exp_q.push_back(ref_model(b, i, s));
    @(posedge clk);
    #1;
    if (held_v) begin
      check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall_instr", bus.out_instr, held_instr);
      check("stall_err", {31'b0, bus.out_err}, {31'b0, held_err});
    end
    check("err_count", {24'b0, bus.err_count}, model_cnt);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    held_v    = 1'b0;
  endtask

  vec_t tbl[10];
  int   vcount, run, max_run;

  initial begin
    tbl[0] = '{OPC_OP_IMM, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0013, 1'b0};
    tbl[1] = '{OPC_STORE,  32'h0000_07FF, 3'b001, 32'h7E00_2FA3, 1'b0};
    tbl[2] = '{OPC_BRANCH, 32'h0000_0003, 3'b010, 32'h0000_0163, 1'b1};
    tbl[3] = '{OPC_BRANCH, 32'h0000_1000, 3'b010, 32'h8000_0063, 1'b1};
    tbl[4] = '{OPC_LUI,    32'h1234_5000, 3'b011, 32'h1234_5037, 1'b0};
    tbl[5] = '{OPC_JAL,    32'hFFFF_FFFE, 3'b100, 32'hFFFF_F06F, 1'b0};
    tbl[6] = '{OPC_OP_IMM, 32'h0000_07FF, 3'b101, 32'h7FF0_0013, 1'b0};
    tbl[7] = '{OPC_OP_IMM, 32'h0000_0800, 3'b000, 32'h8000_0013, 1'b1};
    tbl[8] = '{OPC_LUI,    32'h1234_5001, 3'b011, 32'h1234_5037, 1'b1};
    tbl[9] = '{OPC_OP_IMM, 32'h0000_0005, 3'b110, 32'h0000_0013, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.base_instr = '0; bus.imm = '0; bus.ImmSrc = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; model_cnt = 0; held_v = 1'b0;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    check("rst_err_count", {24'b0, bus.err_count}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    foreach (tbl[k]) begin
      cycle(1'b1, tbl[k].base, tbl[k].imm, tbl[k].src, 1'b1);
      check("latency_early", {31'b0, bus.out_valid}, 32'd0);
      cycle(1'b0, '0, '0, '0, 1'b1);
      check("latency_valid", {31'b0, bus.out_valid}, 32'd1);
      check("tbl_instr", bus.out_instr, tbl[k].exp_instr);
      check("tbl_err", {31'b0, bus.out_err}, {31'b0, tbl[k].exp_err});
      cycle(1'b0, '0, '0, '0, 1'b1);
    end

    do_reset();
    cycle(1'b1, OPC_BRANCH, 32'h0000_0003, IMM_B, 1'b1);
    cycle(1'b1, OPC_BRANCH, 32'h0000_1000, IMM_B, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1);
    check("b_err_count", {24'b0, bus.err_count}, 32'd2);

    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) cycle(1'($urandom_range(0, 1)), OPC_LUI, 32'h1234_5000, IMM_U,
                            1'($urandom_range(0, 1)));
      else cycle(1'($urandom_range(0, 1)), OPC_JAL, 32'hFFFF_FFFE, IMM_J,
                 1'($urandom_range(0, 1)));
    end
    repeat (4) cycle(1'b0, '0, '0, '0, 1'b1);
    check("uj_drained", exp_q.size(), 32'd0);

    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom(), rand_imm(),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (4) cycle(1'b0, '0, '0, '0, 1'b1);
    check("rand_drained", exp_q.size(), 32'd0);

    do_reset();
    vcount = 0; run = 0; max_run = 0;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) begin
        cycle(1'b1, OPC_OP_IMM, 32'(k * 3), IMM_I, 1'b1);
        check("tput_in_ready", {31'b0, last_acc}, 32'd1);
      end else begin
        cycle(1'b0, '0, '0, '0, 1'b1);
      end
      if (bus.out_valid) begin
        vcount++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("tput_valid_cycles", vcount, 32'd16);
    check("tput_consecutive", max_run, 32'd16);

    cycle(1'b1, OPC_OP_IMM, '0, 3'b111, 1'b1);
    cycle(1'b1, OPC_OP_IMM, '0, 3'b110, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1);
    repeat (3) cycle(1'b1, OPC_STORE, 32'h10, IMM_S, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("pre_rst_err_count", {24'b0, bus.err_count}, 32'd2);
    do_reset();
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_err_count", {24'b0, bus.err_count}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    for (int k = 0; k < 300; k++) begin
      cycle(1'b1, $urandom(), $urandom(), 3'($urandom_range(6, 7)), 1'b1);
    end
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1);
    check("sat_err_count", {24'b0, bus.err_count}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
